// File: rtl/bus_pkg.sv
// Shared types and constants for the serial bus matrix.
// State encoding, lane mode values and an index-width helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    SPLIT_RESP
  } state_t;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_matrix_if.sv
// Bus matrix lanes: initiator side and target side, all 1-bit serial.
// slave = matrix view, master = initiator/target environment view.
interface bus_matrix_if #(
  parameter int N_INIT = 4,
  parameter int N_TGT  = 3
);
  logic [N_INIT-1:0] init_req;
  logic [N_INIT-1:0] init_grant;
  logic [N_INIT-1:0] fwd_data;
  logic [N_INIT-1:0] fwd_valid;
  logic [N_INIT-1:0] fwd_mode;
  logic [N_INIT-1:0] fwd_rw;
  logic [N_INIT-1:0] rsp_data;
  logic [N_INIT-1:0] rsp_valid;
  logic [N_INIT-1:0] rsp_ack;
  logic [N_INIT-1:0] rsp_split;
  logic [N_INIT-1:0] rsp_err;
  logic              tgt_data;
  logic              tgt_valid;
  logic              tgt_mode;
  logic              tgt_rw;
  logic [N_TGT-1:0]  tgt_sel;
  logic [N_TGT-1:0]  tgt_rsp_data;
  logic [N_TGT-1:0]  tgt_rsp_valid;
  logic [N_TGT-1:0]  tgt_ack;
  logic [N_TGT-1:0]  tgt_split_ack;
  logic [N_TGT-1:0]  tgt_split_req;
  logic [N_TGT-1:0]  tgt_split_grant;
  logic              busy;

  modport slave (
    input  init_req, fwd_data, fwd_valid,
    input  fwd_mode, fwd_rw,
    input  tgt_rsp_data, tgt_rsp_valid,
    input  tgt_ack, tgt_split_ack,
    input  tgt_split_req,
    output init_grant, rsp_data, rsp_valid,
    output rsp_ack, rsp_split, rsp_err,
    output tgt_data, tgt_valid, tgt_mode,
    output tgt_rw, tgt_sel,
    output tgt_split_grant, busy
  );

  modport master (
    output init_req, fwd_data, fwd_valid,
    output fwd_mode, fwd_rw,
    output tgt_rsp_data, tgt_rsp_valid,
    output tgt_ack, tgt_split_ack,
    output tgt_split_req,
    input  init_grant, rsp_data, rsp_valid,
    input  rsp_ack, rsp_split, rsp_err,
    input  tgt_data, tgt_valid, tgt_mode,
    input  tgt_rw, tgt_sel,
    input  tgt_split_grant, busy
  );
endinterface

// File: rtl/bus_matrix_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins.
// Ports: req, ptr in; one-hot gnt, winner idx, any out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bus_matrix.sv
// Serial bus matrix: RR arbitration, address decode, split tracking.
// Ports: clk, rst (async high), bus (slave). Option: BUS_TIMEOUT_EN.
module bus_matrix
  import bus_pkg::*;
#(
  parameter int                N_INIT      = 4,
  parameter int                N_TGT       = 3,
  parameter logic [N_TGT-1:0]  SPLIT_MASK  = 3'b100,
  parameter int                TSEL_W      = 2,
  parameter int                TIMEOUT_CYC = 256
) (
  input logic       clk,
  input logic       rst,
  bus_matrix_if.slave bus
);
  localparam int OW = idx_w(N_INIT);
  localparam int TW = idx_w(N_TGT);
  localparam int AW = $clog2(TSEL_W + 1);

  if ((2 ** TSEL_W) < N_TGT || TIMEOUT_CYC < 2)
  begin : g_bad_cfg
    $error("bus_matrix: bad parameters");
  end

  state_t            state;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     rr_ptr;
  logic [N_INIT-1:0] grant_q;
  logic [N_INIT-1:0] parked;
  logic [N_TGT-1:0]  sel_q;
  logic [N_TGT-1:0]  sgnt_q;
  logic [N_TGT-1:0]  sp_vld;
  logic [OW-1:0]     sp_own [N_TGT];
  logic [TW-1:0]     sel_idx;
  logic [TSEL_W-1:0] abits;
  logic [AW-1:0]     acnt;
  logic              rw_q;

  logic [N_INIT-1:0] arb_gnt;
  logic [OW-1:0]     arb_idx;
  logic              arb_any;

  logic              own_act, in_rsp;
  logic              o_data, o_valid, o_mode;
  logic              abort, abit, last_bit;
  logic [TSEL_W-1:0] addr_full;
  logic              dec_err, t_ack;
  logic              ack_hit, split_hit, sr_ack;
  logic              sp_any, to_hit;
  logic [TW-1:0]     sp_t;

  rr_arbiter #(.N(N_INIT), .IW(OW)) u_arb (
    .req (bus.init_req & ~parked),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    own_act = (state != IDLE);
    in_rsp  = (state == DATA) ||
              (state == SPLIT_RESP);
    o_data  = own_act && bus.fwd_data[owner];
    o_valid = own_act && bus.fwd_valid[owner];
    o_mode  = own_act && bus.fwd_mode[owner];
    abort   = ((state == ADDR) ||
               (state == DATA)) &&
              !bus.init_req[owner];
    abit    = (state == ADDR) && !abort &&
              o_valid && (o_mode == MODE_ADDR);
    addr_full = TSEL_W'({abits, o_data});
    last_bit  = (acnt == AW'(TSEL_W - 1));
    dec_err   = abit && last_bit &&
                (int'(addr_full) >= N_TGT);
    t_ack     = bus.tgt_ack[sel_idx];
    ack_hit   = (state == DATA) && !abort && t_ack;
    // Ack beats a simultaneous split; split only on capable targets.
    split_hit = (state == DATA) && !abort &&
                !t_ack && bus.tgt_split_ack[sel_idx] &&
                SPLIT_MASK[sel_idx];
    sr_ack    = (state == SPLIT_RESP) && t_ack;
    sp_any = 1'b0;
    sp_t   = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (!sp_any && bus.tgt_split_req[t] &&
          sp_vld[t]) begin
        sp_any = 1'b1;
        sp_t   = TW'(t);
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] tcnt;
  logic          rv, run;

  assign rv     = in_rsp && bus.tgt_rsp_valid[sel_idx];
  assign to_hit = in_rsp && !abort && !t_ack && !rv &&
                  (tcnt == CW'(TIMEOUT_CYC - 1));
  assign run    = in_rsp && !(abort || ack_hit ||
                  split_hit || sr_ack || to_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt <= '0;
    else if (!run || rv)
      tcnt <= '0;
    else
      tcnt <= tcnt + CW'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    bus.rsp_data  = '0;
    bus.rsp_valid = '0;
    bus.rsp_ack   = '0;
    bus.rsp_split = '0;
    bus.rsp_err   = '0;
    if (in_rsp) begin
      bus.rsp_data[owner]  = bus.tgt_rsp_data[sel_idx];
      bus.rsp_valid[owner] = bus.tgt_rsp_valid[sel_idx];
    end
    if (own_act) begin
      bus.rsp_ack[owner]   = ack_hit || sr_ack;
      bus.rsp_split[owner] = split_hit;
      bus.rsp_err[owner]   = dec_err || to_hit;
    end
  end

  assign bus.tgt_data        = o_data;
  assign bus.tgt_valid       = o_valid;
  assign bus.tgt_mode        = o_mode;
  assign bus.tgt_rw          = own_act ?
                               bus.fwd_rw[owner] : rw_q;
  assign bus.init_grant      = grant_q;
  assign bus.tgt_sel         = sel_q;
  assign bus.tgt_split_grant = sgnt_q;
  assign bus.busy            = own_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
      parked  <= '0;
      sel_q   <= '0;
      sgnt_q  <= '0;
      sp_vld  <= '0;
      sel_idx <= '0;
      abits   <= '0;
      acnt    <= '0;
      rw_q    <= 1'b0;
      for (int t = 0; t < N_TGT; t++)
        sp_own[t] <= '0;
    end else begin
      if (own_act)
        rw_q <= bus.fwd_rw[owner];
      unique case (state)
        IDLE: begin
          acnt  <= '0;
          abits <= '0;
          if (sp_any) begin
            state   <= SPLIT_RESP;
            owner   <= sp_own[sp_t];
            sel_idx <= sp_t;
            sgnt_q  <= N_TGT'(1) << sp_t;
            grant_q <= N_INIT'(1) << sp_own[sp_t];
          end else if (arb_any) begin
            state   <= ADDR;
            owner   <= arb_idx;
            grant_q <= arb_gnt;
          end
        end
        ADDR: begin
          if (abort || dec_err) begin
            state   <= IDLE;
            grant_q <= '0;
          end else if (abit) begin
            abits <= addr_full;
            acnt  <= acnt + AW'(1);
            if (last_bit) begin
              state   <= DATA;
              sel_idx <= TW'(addr_full);
              sel_q   <= N_TGT'(1) << addr_full;
            end
          end
        end
        DATA: begin
          if (abort || ack_hit ||
              split_hit || to_hit) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
          end
          if (ack_hit)
            rr_ptr <= (int'(owner) == N_INIT - 1) ?
                      '0 : owner + OW'(1);
          if (split_hit) begin
            sp_vld[sel_idx] <= 1'b1;
            sp_own[sel_idx] <= owner;
            parked[owner]   <= 1'b1;
          end
        end
        SPLIT_RESP: begin
          if (sr_ack || to_hit) begin
            state           <= IDLE;
            grant_q         <= '0;
            sgnt_q          <= '0;
            sp_vld[sel_idx] <= 1'b0;
            parked[owner]   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_matrix.sv
// Directed self-checking bench for bus_matrix (4 init, 3 tgt).
// Timeout scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_bus_matrix;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bus_matrix_if #(.N_INIT(4), .N_TGT(3)) bus ();

  bus_matrix #(
    .N_INIT(4), .N_TGT(3), .SPLIT_MASK(3'b100),
    .TSEL_W(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.init_req      = '0;
    bus.fwd_data      = '0;
    bus.fwd_valid     = '0;
    bus.fwd_mode      = '0;
    bus.fwd_rw        = '0;
    bus.tgt_rsp_data  = '0;
    bus.tgt_rsp_valid = '0;
    bus.tgt_ack       = '0;
    bus.tgt_split_ack = '0;
    bus.tgt_split_req = '0;
  endtask

  task automatic drive_bit(input int o, input logic b);
    bus.fwd_valid    = '0;
    bus.fwd_data     = '0;
    bus.fwd_mode     = '0;
    bus.fwd_valid[o] = 1'b1;
    bus.fwd_data[o]  = b;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.init_grant !== 4'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_grant_busy got=%b/%b exp=0000/0",
               bus.init_grant, bus.busy);
    end
    total++;
    if (bus.tgt_sel !== 3'b0 || bus.tgt_rw !== 1'b0 ||
        bus.rsp_err !== 4'b0) begin
      bad++;
      $display("FAIL reset_outs sel=%b rw=%b err=%b exp=0",
               bus.tgt_sel, bus.tgt_rw, bus.rsp_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.init_req = 4'b0110;
    step();
    total++;
    if (bus.init_grant !== 4'b0010) begin
      bad++;
      $display("FAIL rr_first_grant got=%b exp=0010",
               bus.init_grant);
    end
    drive_bit(1, 1'b1);
    #1;
    total++;
    if (bus.tgt_data !== 1'b1 || bus.tgt_valid !== 1'b1) begin
      bad++;
      $display("FAIL fwd_mux got=%b%b exp=11",
               bus.tgt_data, bus.tgt_valid);
    end
    step();
    drive_bit(1, 1'b0);
    step();
    bus.fwd_valid = '0;
    total++;
    if (bus.tgt_sel !== 3'b100) begin
      bad++;
      $display("FAIL b2b_sel got=%b exp=100", bus.tgt_sel);
    end
    bus.tgt_ack[2] = 1'b1;
    #1;
    total++;
    if (bus.rsp_ack !== 4'b0010) begin
      bad++;
      $display("FAIL b2b_ack got=%b exp=0010", bus.rsp_ack);
    end
    step();
    bus.tgt_ack = '0;
    total++;
    if (bus.init_grant !== 4'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got=%b/%b exp=0000/0",
               bus.init_grant, bus.busy);
    end
    step();
    total++;
    if (bus.init_grant !== 4'b0100) begin
      bad++;
      $display("FAIL b2b_next_grant got=%b exp=0100",
               bus.init_grant);
    end
    bus.init_req = '0;
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_ack !== 4'b0) begin
      bad++;
      $display("FAIL abort got busy=%b ack=%b exp=0/0000",
               bus.busy, bus.rsp_ack);
    end
  endtask

  task automatic test_addr_decode();
    bus.init_req = 4'b0001;
    step();
    drive_bit(0, 1'b1);
    step();
    drive_bit(0, 1'b0);
    #1;
    total++;
    if (bus.tgt_sel !== 3'b000) begin
      bad++;
      $display("FAIL sel_early got=%b exp=000", bus.tgt_sel);
    end
    step();
    bus.fwd_valid = '0;
    total++;
    if (bus.tgt_sel !== 3'b100) begin
      bad++;
      $display("FAIL sel_t2 got=%b exp=100", bus.tgt_sel);
    end
    bus.tgt_rsp_data[2]  = 1'b1;
    bus.tgt_rsp_valid[2] = 1'b1;
    #1;
    total++;
    if (bus.rsp_data !== 4'b0001 ||
        bus.rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL rsp_pass got=%b/%b exp=0001/0001",
               bus.rsp_data, bus.rsp_valid);
    end
    bus.tgt_rsp_data  = '0;
    bus.tgt_rsp_valid = '0;
    bus.tgt_ack[2]    = 1'b1;
    #1;
    total++;
    if (bus.rsp_ack !== 4'b0001) begin
      bad++;
      $display("FAIL ack_owner0 got=%b exp=0001", bus.rsp_ack);
    end
    step();
    bus.tgt_ack  = '0;
    bus.init_req = '0;
    step();
  endtask

  task automatic test_decode_err();
    bus.init_req = 4'b0001;
    step();
    drive_bit(0, 1'b1);
    step();
    drive_bit(0, 1'b1);
    #1;
    total++;
    if (bus.rsp_err !== 4'b0001) begin
      bad++;
      $display("FAIL dec_err got=%b exp=0001", bus.rsp_err);
    end
    step();
    bus.fwd_valid = '0;
    bus.init_req  = '0;
    total++;
    if (bus.busy !== 1'b0 || bus.tgt_sel !== 3'b0 ||
        bus.rsp_err !== 4'b0) begin
      bad++;
      $display("FAIL dec_after got busy=%b sel=%b err=%b exp=0",
               bus.busy, bus.tgt_sel, bus.rsp_err);
    end
    step();
  endtask

  task automatic test_split();
    bus.tgt_split_req[1] = 1'b1;
    step();
    bus.tgt_split_req = '0;
    total++;
    if (bus.busy !== 1'b0 || bus.tgt_split_grant !== 3'b0) begin
      bad++;
      $display("FAIL stray_sreq got=%b/%b exp=0/000",
               bus.busy, bus.tgt_split_grant);
    end
    bus.init_req = 4'b0010;
    step();
    drive_bit(1, 1'b1);
    step();
    drive_bit(1, 1'b0);
    step();
    bus.fwd_valid = '0;
    bus.tgt_split_ack[2] = 1'b1;
    #1;
    total++;
    if (bus.rsp_split !== 4'b0010 || bus.rsp_ack !== 4'b0) begin
      bad++;
      $display("FAIL split_acc got=%b/%b exp=0010/0000",
               bus.rsp_split, bus.rsp_ack);
    end
    step();
    bus.tgt_split_ack = '0;
    bus.init_req = 4'b0011;
    step();
    total++;
    if (bus.init_grant !== 4'b0001) begin
      bad++;
      $display("FAIL park_skip got=%b exp=0001", bus.init_grant);
    end
    drive_bit(0, 1'b0);
    step();
    drive_bit(0, 1'b0);
    step();
    bus.fwd_valid = '0;
    bus.tgt_split_ack[0] = 1'b1;
    #1;
    total++;
    if (bus.rsp_split !== 4'b0) begin
      bad++;
      $display("FAIL nonsplit_ign got=%b exp=0000", bus.rsp_split);
    end
    step();
    bus.tgt_split_ack = '0;
    total++;
    if (bus.busy !== 1'b1 || bus.tgt_sel !== 3'b001) begin
      bad++;
      $display("FAIL nonsplit_hold got=%b/%b exp=1/001",
               bus.busy, bus.tgt_sel);
    end
    bus.tgt_ack[0] = 1'b1;
    #1;
    total++;
    if (bus.rsp_ack !== 4'b0001) begin
      bad++;
      $display("FAIL nonsplit_ack got=%b exp=0001", bus.rsp_ack);
    end
    step();
    bus.tgt_ack  = '0;
    bus.init_req = 4'b0010;
    step();
    total++;
    if (bus.init_grant !== 4'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL parked_nogrant got=%b/%b exp=0000/0",
               bus.init_grant, bus.busy);
    end
    bus.tgt_split_req[2] = 1'b1;
    step();
    total++;
    if (bus.init_grant !== 4'b0010 ||
        bus.tgt_split_grant !== 3'b100) begin
      bad++;
      $display("FAIL sresp_grant got=%b/%b exp=0010/100",
               bus.init_grant, bus.tgt_split_grant);
    end
    bus.tgt_rsp_data[2]  = 1'b1;
    bus.tgt_rsp_valid[2] = 1'b1;
    #1;
    total++;
    if (bus.rsp_data !== 4'b0010 ||
        bus.rsp_valid !== 4'b0010) begin
      bad++;
      $display("FAIL sresp_route got=%b/%b exp=0010/0010",
               bus.rsp_data, bus.rsp_valid);
    end
    bus.tgt_rsp_data  = '0;
    bus.tgt_rsp_valid = '0;
    bus.tgt_ack[2]    = 1'b1;
    #1;
    total++;
    if (bus.rsp_ack !== 4'b0010) begin
      bad++;
      $display("FAIL sresp_ack got=%b exp=0010", bus.rsp_ack);
    end
    step();
    bus.tgt_ack       = '0;
    bus.tgt_split_req = '0;
    step();
    total++;
    if (bus.init_grant !== 4'b0010) begin
      bad++;
      $display("FAIL unpark got=%b exp=0010", bus.init_grant);
    end
    bus.init_req = '0;
    step();
  endtask

  task automatic test_rst_mid();
    bus.init_req = 4'b0001;
    step();
    drive_bit(0, 1'b0);
    step();
    drive_bit(0, 1'b1);
    step();
    bus.fwd_valid = '0;
    bus.tgt_rsp_valid[1] = 1'b1;
    #1;
    total++;
    if (bus.tgt_sel !== 3'b010 || bus.rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL pre_rst got=%b/%b exp=010/0001",
               bus.tgt_sel, bus.rsp_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.init_grant !== 4'b0 ||
        bus.tgt_sel !== 3'b0 || bus.rsp_valid !== 4'b0) begin
      bad++;
      $display("FAIL async_rst got b=%b g=%b s=%b v=%b exp=0",
               bus.busy, bus.init_grant, bus.tgt_sel,
               bus.rsp_valid);
    end
    idle_in();
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    bus.init_req = 4'b0001;
    step();
    drive_bit(0, 1'b0);
    step();
    drive_bit(0, 1'b0);
    step();
    bus.fwd_valid = '0;
    for (int k = 1; k < 16; k++) begin
      #1;
      if (bus.rsp_err !== 4'b0)
        early++;
      step();
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL to_early got=%0d exp=0", early);
    end
    #1;
    total++;
    if (bus.rsp_err !== 4'b0001) begin
      bad++;
      $display("FAIL to_fire got=%b exp=0001", bus.rsp_err);
    end
    step();
    bus.init_req = '0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL to_idle got=%b exp=0", bus.busy);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_addr_decode();
    test_decode_err();
    test_split();
    test_rst_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
